// File: rtl/simplerisc_pkg.sv
// simplerisc_pkg: shared SimpleRISC constants, MA-stage state encoding and field helpers
package simplerisc_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  typedef enum logic [1:0] {IDLE = S_IDLE, BUSY = S_BUSY, DONE = S_DONE} ma_state_t;
  localparam logic [31:0] NOP_INST = 32'h6800_0000;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int IMM_BIT = 26;
  function automatic logic [4:0] opcode(input logic [31:0] inst);
    return inst[OPC_MSB:OPC_LSB];
  endfunction
endpackage

// File: rtl/ma_stage_ctrl_if.sv
// ma_stage_ctrl_if: data-memory request/response bus between the MA stage and data memory
interface ma_stage_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  modport master(output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
  modport slave(input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/ma_timeout_ctr.sv
// ma_timeout_ctr: saturating BUSY-cycle counter that flags the last allowed wait cycle
module ma_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int W = $clog2(TIMEOUT) + 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = clr_i ? '0 : (en_i && cnt_q != W'(TIMEOUT)) ? cnt_q + 1'b1 : cnt_q;
  assign expired_o = en_i && cnt_q >= W'(TIMEOUT - 1);
  // count cycles spent waiting, holding at TIMEOUT so it never wraps
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/ma_stage_ctrl.sv
// ma_stage_ctrl: MA-stage controller running loads/stores as handshaked memory transactions
module ma_stage_ctrl #(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] NOP_INST = simplerisc_pkg::NOP_INST
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_MA,
  input  logic [31:0]           inst_MA,
  input  logic                  is_Ld_MA,
  input  logic                  is_St_MA,
  input  logic [31:0]           aluResult_MA,
  input  logic [31:0]           op2_MA,
  input  logic [4:0]            rd_MA,
  input  logic                  isWb_MA,
  output logic                  stall_MA,
  ma_stage_ctrl_if.master       mem,
  output logic [31:0]           inst_DM,
  output logic                  is_Ld_DM,
  output logic [31:0]           aluResult_DM,
  output logic [31:0]           DMResult_DM,
  output logic [4:0]            rd_DM,
  output logic                  isWb_DM,
  output logic                  mem_err
);
  import simplerisc_pkg::*;
  ma_state_t   state_q, state_d;
  logic [31:0] inst_q, addr_q, wdata_q, data_q, data_d;
  logic [4:0]  rd_q;
  logic        ld_q, st_q, wb_q, err_q, err_d, req_q;
  logic        busy, done, mem_op, start, pass, expired;
  assign busy   = state_q == BUSY;
  assign done   = state_q == DONE;
  assign mem_op = valid_MA && (is_Ld_MA || is_St_MA);
  assign start  = state_q == IDLE && mem_op;
  assign pass   = rst_n && state_q == IDLE && !mem_op;
  ma_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk(clk), .rst_n(rst_n), .clr_i(start), .en_i(busy), .expired_o(expired)
  );
  // next state, completion data and sticky error; ack beats a simultaneous timeout
  always_comb begin
    state_d = start ? BUSY : (busy && (mem.mem_ack || expired)) ? DONE : done ? IDLE : state_q;
    data_d  = (busy && mem.mem_ack) ? (ld_q ? mem.mem_rdata : '0) : (busy && expired) ? '0 : data_q;
    err_d   = err_q || (busy && expired && !mem.mem_ack);
  end
  // state, request and hold registers; mem_req is registered off the next state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      inst_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      wb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= state_d == BUSY;
      err_q   <= err_d;
      data_q  <= data_d;
      if (start) begin
        inst_q  <= inst_MA;
        addr_q  <= aluResult_MA;
        wdata_q <= op2_MA;
        rd_q    <= rd_MA;
        ld_q    <= is_Ld_MA;
        st_q    <= is_St_MA;
        wb_q    <= isWb_MA;
      end
    end
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = req_q && st_q;
  assign mem.mem_addr  = req_q ? addr_q : '0;
  assign mem.mem_wdata = req_q ? wdata_q : '0;
  assign stall_MA      = rst_n && (start || busy);
  assign mem_err       = err_q;
  assign inst_DM       = done ? inst_q : pass ? inst_MA : NOP_INST;
  assign is_Ld_DM      = done ? ld_q : pass && is_Ld_MA;
  assign aluResult_DM  = done ? addr_q : pass ? aluResult_MA : '0;
  assign DMResult_DM   = done ? data_q : '0;
  assign rd_DM         = done ? rd_q : pass ? rd_MA : '0;
  assign isWb_DM       = done ? wb_q : pass && isWb_MA;
endmodule

// File: tb/tb_ma_stage_ctrl.sv
// tb_ma_stage_ctrl: table vectors, directed corner sequences and random ops against a transaction model
module tb_ma_stage_ctrl;
  localparam int T = 16;
  localparam logic [31:0] NOP = 32'h6800_0000;
  logic clk = 1'b0, rst_n;
  logic valid_MA, is_Ld_MA, is_St_MA, isWb_MA, stall_MA, is_Ld_DM, isWb_DM, mem_err;
  logic [31:0] inst_MA, aluResult_MA, op2_MA, inst_DM, aluResult_DM, DMResult_DM;
  logic [4:0] rd_MA, rd_DM;
  int n_cmp = 0, n_err = 0;
  bit err_exp = 0;
  ma_stage_ctrl_if mif();
  ma_stage_ctrl #(.TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .valid_MA(valid_MA), .inst_MA(inst_MA), .is_Ld_MA(is_Ld_MA),
    .is_St_MA(is_St_MA), .aluResult_MA(aluResult_MA), .op2_MA(op2_MA), .rd_MA(rd_MA),
    .isWb_MA(isWb_MA), .stall_MA(stall_MA), .mem(mif), .inst_DM(inst_DM), .is_Ld_DM(is_Ld_DM),
    .aluResult_DM(aluResult_DM), .DMResult_DM(DMResult_DM), .rd_DM(rd_DM), .isWb_DM(isWb_DM),
    .mem_err(mem_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic v; logic [31:0] inst; logic ld, st; logic [31:0] alu; logic [4:0] rd; logic wb;
    logic [31:0] e_inst; logic e_ld; logic [31:0] e_alu; logic [4:0] e_rd; logic e_wb;
  } vec_t;
  vec_t tbl[5];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic rand_in;
    valid_MA = 1'($urandom); inst_MA = $urandom; is_Ld_MA = 1'($urandom); is_St_MA = 1'($urandom);
    aluResult_MA = $urandom; op2_MA = $urandom; rd_MA = 5'($urandom); isWb_MA = 1'($urandom);
  endtask
  // one non-memory instruction: combinational pass-through, stray ack ignored
  task automatic run_alu(input string tag, input logic v, input logic [31:0] inst, input logic [31:0] alu,
                         input logic [4:0] rd, input logic wb);
    valid_MA = v; inst_MA = inst; is_Ld_MA = 0; is_St_MA = 0; aluResult_MA = alu;
    op2_MA = $urandom; rd_MA = rd; isWb_MA = wb; mif.mem_ack = 1'($urandom); mif.mem_rdata = $urandom;
    @(negedge clk);
    chk({tag, ".stall"}, 32'(stall_MA), 0);
    chk({tag, ".inst"}, inst_DM, inst);
    chk({tag, ".alu"}, aluResult_DM, alu);
    chk({tag, ".rd"}, 32'(rd_DM), 32'(rd));
    chk({tag, ".wb"}, 32'(isWb_DM), 32'(wb));
    chk({tag, ".dm"}, DMResult_DM, 0);
    chk({tag, ".req"}, 32'(mif.mem_req), 0);
    chk({tag, ".err"}, 32'(mem_err), 32'(err_exp));
    step;
  endtask
  // one memory instruction acked in BUSY cycle d (d > T means never acked)
  task automatic run_mem(input string tag, input logic ld, input logic [31:0] inst, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdata, input logic [4:0] rd,
                         input logic wb, input int d);
    int n = (d <= T) ? d : T;
    logic [31:0] res = (ld && d <= T) ? rdata : 32'h0;
    valid_MA = 1; inst_MA = inst; is_Ld_MA = ld; is_St_MA = !ld; aluResult_MA = addr; op2_MA = wd;
    rd_MA = rd; isWb_MA = wb; mif.mem_ack = 1'($urandom); mif.mem_rdata = $urandom;
    @(negedge clk);
    chk({tag, ".arr.stall"}, 32'(stall_MA), 1);
    chk({tag, ".arr.req"}, 32'(mif.mem_req), 0);
    chk({tag, ".arr.inst"}, inst_DM, NOP);
    chk({tag, ".arr.dm"}, DMResult_DM, 0);
    step;
    for (int k = 1; k <= n; k++) begin
      rand_in;
      mif.mem_ack = (k == d);
      mif.mem_rdata = (k == d) ? rdata : $urandom;
      @(negedge clk);
      chk({tag, ".busy.req"}, 32'(mif.mem_req), 1);
      chk({tag, ".busy.we"}, 32'(mif.mem_we), 32'(!ld));
      chk({tag, ".busy.addr"}, mif.mem_addr, addr);
      chk({tag, ".busy.wdata"}, mif.mem_wdata, wd);
      chk({tag, ".busy.stall"}, 32'(stall_MA), 1);
      chk({tag, ".busy.inst"}, inst_DM, NOP);
      chk({tag, ".busy.wb"}, 32'(isWb_DM), 0);
      step;
    end
    if (d > T) err_exp = 1;
    rand_in;
    mif.mem_ack = 1'($urandom);
    @(negedge clk);
    chk({tag, ".done.stall"}, 32'(stall_MA), 0);
    chk({tag, ".done.inst"}, inst_DM, inst);
    chk({tag, ".done.ld"}, 32'(is_Ld_DM), 32'(ld));
    chk({tag, ".done.alu"}, aluResult_DM, addr);
    chk({tag, ".done.dm"}, DMResult_DM, res);
    chk({tag, ".done.rd"}, 32'(rd_DM), 32'(rd));
    chk({tag, ".done.wb"}, 32'(isWb_DM), 32'(wb));
    chk({tag, ".done.req"}, 32'(mif.mem_req), 0);
    chk({tag, ".done.err"}, 32'(mem_err), 32'(err_exp));
    step;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{1, 32'h00C4_0008, 0, 0, 32'h0000_0007, 5'd3, 1, 32'h00C4_0008, 0, 32'h0000_0007, 5'd3, 1};
    tbl[1] = '{0, 32'h7000_0040, 1, 0, 32'h0000_0040, 5'd9, 1, 32'h7000_0040, 1, 32'h0000_0040, 5'd9, 1};
    tbl[2] = '{0, 32'h7800_0080, 0, 1, 32'h0000_0080, 5'd2, 0, 32'h7800_0080, 0, 32'h0000_0080, 5'd2, 0};
    tbl[3] = '{1, 32'h2880_0000, 0, 0, 32'hFFFF_FFFF, 5'd0, 0, 32'h2880_0000, 0, 32'hFFFF_FFFF, 5'd0, 0};
    tbl[4] = '{1, 32'h0842_0003, 0, 0, 32'h8000_0000, 5'd31, 1, 32'h0842_0003, 0, 32'h8000_0000, 5'd31, 1};
    rst_n = 0; valid_MA = 1; inst_MA = 32'h7000_0040; is_Ld_MA = 1; is_St_MA = 0; aluResult_MA = 32'h40;
    op2_MA = 0; rd_MA = 5'd4; isWb_MA = 1; mif.mem_ack = 0; mif.mem_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.stall", 32'(stall_MA), 0);
    chk("rst.inst", inst_DM, NOP);
    chk("rst.rd", 32'(rd_DM), 0);
    chk("rst.req", 32'(mif.mem_req), 0);
    chk("rst.err", 32'(mem_err), 0);
    @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      valid_MA = tbl[i].v; inst_MA = tbl[i].inst; is_Ld_MA = tbl[i].ld; is_St_MA = tbl[i].st;
      aluResult_MA = tbl[i].alu; rd_MA = tbl[i].rd; isWb_MA = tbl[i].wb; mif.mem_ack = 0;
      @(negedge clk);
      chk($sformatf("tbl%0d.inst", i), inst_DM, tbl[i].e_inst);
      chk($sformatf("tbl%0d.ld", i), 32'(is_Ld_DM), 32'(tbl[i].e_ld));
      chk($sformatf("tbl%0d.alu", i), aluResult_DM, tbl[i].e_alu);
      chk($sformatf("tbl%0d.rd", i), 32'(rd_DM), 32'(tbl[i].e_rd));
      chk($sformatf("tbl%0d.wb", i), 32'(isWb_DM), 32'(tbl[i].e_wb));
      chk($sformatf("tbl%0d.stall", i), 32'(stall_MA), 0);
      chk($sformatf("tbl%0d.dm", i), DMResult_DM, 0);
      step;
    end
    run_mem("load", 1, 32'h7000_0040, 32'h40, 32'h0, 32'hDEAD_BEEF, 5'd5, 1, 2);
    run_mem("store", 0, 32'h7800_0080, 32'h80, 32'h1234, 32'h5555_AAAA, 5'd6, 0, 1);
    run_mem("ack16", 1, 32'h7000_0100, 32'h100, 32'h0, 32'hCAFE_F00D, 5'd7, 1, T);
    run_mem("timeout", 1, 32'h7000_0200, 32'h200, 32'h0, 32'h1111_2222, 5'd8, 1, T + 1);
    run_alu("sticky", 1, 32'h00C4_0008, 32'h7, 5'd3, 1);
    run_mem("b2b.ld", 1, 32'h7000_0300, 32'h300, 32'h0, 32'h0BAD_CAFE, 5'd1, 1, 1);
    run_mem("b2b.st", 0, 32'h7800_0304, 32'h304, 32'h9999, 32'h7777_7777, 5'd2, 0, 1);
    run_alu("b2b.add", 1, 32'h00C4_0008, 32'h0000_0007, 5'd3, 1);
    for (int i = 0; i < 40; i++) begin
      int k = int'($urandom_range(0, 2));
      if (k == 0) run_alu("rnd.alu", 1'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom));
      else run_mem("rnd.mem", k == 1, $urandom, $urandom, $urandom, $urandom, 5'($urandom),
                   1'($urandom), int'($urandom_range(1, T + 2)));
    end
    valid_MA = 1; inst_MA = 32'h7000_0400; is_Ld_MA = 1; is_St_MA = 0; aluResult_MA = 32'h400;
    mif.mem_ack = 0;
    step;
    step;
    @(negedge clk);
    chk("rstbusy.pre.req", 32'(mif.mem_req), 1);
    #2 rst_n = 0;
    #1;
    chk("rstbusy.req", 32'(mif.mem_req), 0);
    chk("rstbusy.stall", 32'(stall_MA), 0);
    chk("rstbusy.inst", inst_DM, NOP);
    chk("rstbusy.err", 32'(mem_err), 0);
    err_exp = 0;
    @(posedge clk);
    #1 rst_n = 1;
    run_alu("post_rst", 0, NOP, 32'h0, 5'd0, 0);
    run_mem("post_rst.ld", 1, 32'h7000_0500, 32'h500, 32'h0, 32'h1357_9BDF, 5'd9, 1, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ma_stage_ctrl.md
# ma_stage_ctrl

Memory-access stage controller for the SimpleRISC pipeline. It sits between the EX/MA pipeline register and the DM/WB pipeline register, and it is the producer side of the DM/WB interface. It runs each load/store instruction as a handshaked transaction to data memory and stalls upstream stages while that transaction is outstanding. It drives a bubble into DM/WB until the result is ready, then presents the completed instruction with its load data.

## Interface

Parameters:
- `TIMEOUT`, 16: maximum BUSY cycles to wait for `mem_ack` before forcing completion.
- `NOP_INST`, 32'h6800_0000: SimpleRISC `nop` encoding, driven on `inst_DM` during bubbles.

Ports:
- `clk`  in  1  clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `valid_MA`  in  1  EX/MA register holds a live instruction.
- `inst_MA`  in  32  instruction word.
- `is_Ld_MA` / `is_St_MA`  in  1 each  load / store flags.
- `aluResult_MA`  in  32  ALU result; this is the address for `ld`/`st`.
- `op2_MA`  in  32  store data.
- `rd_MA`  in  5  destination register.
- `isWb_MA`  in  1  instruction writes back.
- `stall_MA`  out  1  holds the PC, IF/OF, OF/EX and EX/MA registers.
- `mem_req`  out  1  data-memory request (registered).
- `mem_we`  out  1  1 = store.
- `mem_addr`  out  32  data-memory address.
- `mem_wdata`  out  32  data-memory write data.
- `mem_rdata`  in  32  data-memory read data; valid when `mem_ack` = 1.
- `mem_ack`  in  1  transaction complete.
- `inst_DM`, `is_Ld_DM`, `aluResult_DM` (32), `DMResult_DM` (32), `rd_DM` (5), `isWb_DM`  out  feed the DM/WB register inputs.
- `mem_err`  out  1  sticky flag, set by a timeout.

## Operation

States (shared enum): IDLE, BUSY, DONE.

- **IDLE**
  - No memory op present (`valid_MA`=0, or neither `is_Ld_MA` nor `is_St_MA` set):
    - pass-through: `inst/is_Ld/aluResult/rd/isWb` go combinationally to the `_DM` outputs;
    - `DMResult_DM`=0;
    - `stall_MA`=0.
  - `valid_MA` & (`is_Ld_MA` | `is_St_MA`):
    - capture inst, flags, address, store data, rd and isWb into hold registers;
    - `stall_MA`=1;
    - drive a bubble;
    - next state BUSY.
- **BUSY**
  - Drive `mem_req`=1 and `mem_we`=held store flag.
  - Drive `mem_addr`/`mem_wdata` from the hold registers.
  - `stall_MA`=1; drive a bubble.
  - Count cycles in BUSY.
  - On `mem_ack`: latch `mem_rdata` (loads; stores latch 0), then go to DONE.
  - If the count reaches `TIMEOUT` with no ack: latch 0, set `mem_err`, go to DONE.
  - If ack and timeout occur in the same cycle, ack wins and `mem_err` is not set.
- **DONE**
  - Drive the held instruction on the `_DM` outputs, with `DMResult_DM` = latched data.
  - `stall_MA`=0, so EX/MA advances at this edge.
  - Next state is IDLE unconditionally; the EX/MA inputs are ignored this cycle.
- **Bubble**: `inst_DM`=`NOP_INST`; `is_Ld_DM`=`isWb_DM`=0; `rd_DM`=0; `aluResult_DM`=`DMResult_DM`=0.
- `mem_ack` outside BUSY is ignored.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are 0 outside BUSY.
- `mem_err` clears only on reset.

## Timing

- **Reset** (async assert, sync deassert):
  - state IDLE, BUSY counter 0;
  - hold and data registers 0;
  - `mem_req`=0, `mem_err`=0;
  - while `rst_n`=0, `stall_MA`=0 and the `_DM` outputs carry a bubble.
- **Reset mid-BUSY**: `mem_req` drops immediately and the transaction is abandoned; the memory side must tolerate this.
- **Memory-op latency**, ack in the first BUSY cycle:
  - arrival (IDLE) → BUSY → DONE;
  - `stall_MA` is high for 2 cycles;
  - the instruction spends 3 cycles in the stage;
  - each additional wait cycle adds 1.
- **Non-memory ops**: 0 extra cycles; the outputs are combinational.
- **Counter**: width `$clog2(TIMEOUT)+1`; resets on each entry to BUSY and saturates, so it never wraps.
- **Back-to-back memory ops**: the second op is sampled in the IDLE cycle following DONE. Minimum spacing is 3 cycles per op.
- **DM/WB side**: the DM/WB stall is owned by the hazard unit. If it is asserted during DONE, this block does not hold DONE; the hazard unit must not stall DM/WB while `stall_MA` is low.

## Structure

- **Package `simplerisc_pkg`**:
  - `ma_state_t` enum (IDLE/BUSY/DONE);
  - `NOP_INST` constant;
  - opcode field positions.
- **Sub-module `ma_timeout_ctr`**:
  - ports: clear, enable, saturating count, `expired` output;
  - instantiated once.
- All other logic (FSM, hold registers, output mux) is flat in `ma_stage_ctrl`.

## Test plan

- **Reset**: `rst_n`=0 mid-BUSY → `mem_req`=0 the same cycle; after release the state is IDLE, `mem_err`=0, and `inst_DM`=32'h6800_0000 until `valid_MA`.
- **ALU op passthrough**: `add` with `aluResult_MA`=32'h0000_0007, `rd`=3, `isWb`=1 → same-cycle `aluResult_DM`=7, `rd_DM`=3, `isWb_DM`=1, `stall_MA`=0.
- **Load**:
  - stimulus: `ld` with addr 32'h40; `mem_ack` 2 cycles after `mem_req` rises, `mem_rdata`=32'hDEAD_BEEF;
  - response: `stall_MA` high for 3 cycles; in the DONE cycle `DMResult_DM`=32'hDEAD_BEEF and `is_Ld_DM`=1; bubbles before that.
- **Store**: `st` with addr 32'h80, `op2`=32'h1234 → `mem_we`=1, `mem_wdata`=32'h1234 while `mem_req`; `isWb_DM`=0 in DONE.
- **Timeout**: `ld`, never ack → after 16 BUSY cycles `DMResult_DM`=0, `mem_err`=1 and sticky. Ack in cycle 16 → `mem_err`=0.
- **Back-to-back and stray ack**: `ld`, `st`, `add` consecutively with an immediate ack → DONE for the `ld`, IDLE, then the `st` starts; `mem_ack` pulsed in IDLE has no effect.
